// File: rtl/ws2812_pkg.sv
// ws2812_pkg: WS2812 line timing, receiver defaults and decoder state encoding.
package ws2812_pkg;
    localparam int T0H = 40;
    localparam int T0L = 85;
    localparam int T1H = 80;
    localparam int T1L = 45;
    localparam int MIN_HIGH = 15;
    localparam int BIT_THRESH = 60;
    localparam int MAX_HIGH = 120;
    localparam int RES_TIME = 2000;

    typedef enum logic [1:0] {SYNC, IDLE, HIGH, LOW} state_t;

    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction
endpackage

// File: rtl/ws2812_sync.sv
// ws2812_sync: 2-FF synchroniser for the serial line plus rise/fall detection.
module ws2812_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic d_s,
    output logic rise,
    output logic fall
);
    logic s1, d_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) {s1, d_s, d_q} <= 3'b000;
        else        {s1, d_s, d_q} <= {d, s1, d_s};

    assign rise = d_s & ~d_q;
    assign fall = ~d_s & d_q;
endmodule

// File: rtl/ws2812_rx.sv
// ws2812_rx: WS2812 NRZ receiver; decodes pulse widths into GRB pixels,
// marks frame gaps and flags malformed pulses.
module ws2812_rx #(
    parameter int MIN_HIGH   = ws2812_pkg::MIN_HIGH,
    parameter int BIT_THRESH = ws2812_pkg::BIT_THRESH,
    parameter int MAX_HIGH   = ws2812_pkg::MAX_HIGH,
    parameter int RES_TIME   = ws2812_pkg::RES_TIME
) (
    input  logic        clk_100mhz,
    input  logic        reset_n,
    input  logic        d_in,
    output logic [7:0]  red,
    output logic [7:0]  green,
    output logic [7:0]  blue,
    output logic        pix_valid,
    output logic [15:0] pix_idx,
    output logic        frame_end,
    output logic        err
);
    import ws2812_pkg::*;

    logic d_s, rise, fall;
    logic [15:0] cnt;
    state_t state, state_n;
    logic shift, bit_v, err_c, fe_c, low_done;
    int hi_w, run;
    logic [22:0] sr;
    logic [4:0] bit_cnt;
    logic [23:0] word;
    logic word_rdy, err_q, fe_q;
    logic [15:0] next_idx;

    ws2812_sync u_sync (
        .clk  (clk_100mhz),
        .rst_n(reset_n),
        .d    (d_in),
        .d_s  (d_s),
        .rise (rise),
        .fall (fall)
    );

    always_ff @(posedge clk_100mhz or negedge reset_n)
        if (!reset_n)          cnt <= '0;
        else if (rise || fall) cnt <= '0;
        else                   cnt <= sat_inc(cnt);

    // cnt restarts one cycle after an edge: in a fall cycle the finished high
    // lasted cnt+1 cycles, otherwise the current level has lasted cnt+2.
    always_comb begin
        hi_w = int'(cnt) + 1;
        run = int'(cnt) + 2;
        bit_v = hi_w >= BIT_THRESH;
        low_done = !d_s && !fall && run > RES_TIME;
    end

    always_ff @(posedge clk_100mhz or negedge reset_n)
        if (!reset_n) state <= SYNC;
        else          state <= state_n;

    always_comb begin
        state_n = state;
        shift = 1'b0;
        err_c = 1'b0;
        fe_c = 1'b0;
        case (state)
            SYNC: if (low_done) state_n = IDLE;
            IDLE: if (rise) state_n = HIGH;
            HIGH:
                if (fall) begin
                    err_c = hi_w < MIN_HIGH;
                    shift = !err_c;
                    state_n = err_c ? SYNC : LOW;
                end else if (run > MAX_HIGH) begin
                    err_c = 1'b1;
                    state_n = SYNC;
                end
            LOW:
                if (rise) state_n = HIGH;
                else if (low_done) begin
                    fe_c = 1'b1;
                    err_c = bit_cnt != 5'd0;
                    state_n = IDLE;
                end
            default: state_n = SYNC;
        endcase
    end

    always_ff @(posedge clk_100mhz or negedge reset_n)
        if (!reset_n) begin
            sr <= '0;
            bit_cnt <= '0;
            word <= '0;
            word_rdy <= 1'b0;
            err_q <= 1'b0;
            fe_q <= 1'b0;
        end else begin
            word_rdy <= 1'b0;
            err_q <= err_c;
            fe_q <= fe_c;
            if (shift) begin
                sr <= {sr[21:0], bit_v};
                bit_cnt <= (bit_cnt == 5'd23) ? 5'd0 : bit_cnt + 5'd1;
                if (bit_cnt == 5'd23) begin
                    word <= {sr, bit_v};
                    word_rdy <= 1'b1;
                end
            end else if (err_c || fe_c) begin
                bit_cnt <= '0;
            end
        end

    // Output stage: one register after the decoder so all pulses share latency.
    always_ff @(posedge clk_100mhz or negedge reset_n)
        if (!reset_n) begin
            {green, red, blue} <= '0;
            pix_valid <= 1'b0;
            err <= 1'b0;
            frame_end <= 1'b0;
            pix_idx <= '0;
            next_idx <= '0;
        end else begin
            pix_valid <= word_rdy;
            err <= err_q;
            frame_end <= fe_q;
            if (word_rdy) begin
                {green, red, blue} <= word;
                pix_idx <= next_idx;
                next_idx <= sat_inc(next_idx);
            end
            if (fe_q) begin
                pix_idx <= '0;
                next_idx <= '0;
            end
        end
endmodule

// File: tb/tb_ws2812_rx.sv
// tb_ws2812_rx: random and directed WS2812 traffic against a pulse-width
// reference model, plus literal checks of pixels, indices and pulse timing.
module tb_ws2812_rx;
    import ws2812_pkg::*;

    typedef struct packed {
        logic pv;
        logic er;
        logic fe;
        logic [23:0] px;
    } ev_t;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic d_in = 1'b0;
    logic [7:0] red, green, blue;
    logic pix_valid, frame_end, err;
    logic [15:0] pix_idx;

    int checks = 0, fails = 0, cyc = 0;
    int pv_n = 0, err_n = 0, fe_n = 0;
    int pv_cyc = 0, err_cyc = 0, fe_cyc = 0;
    int last_set = 0, last_fall = 0;
    logic [23:0] last_grb = '0;
    int last_idx = 0;
    int idx_log[8];

    // reference model state
    int mode = 0, run = 0, width = 0, nbits = 0;
    logic lvl = 1'b0, s1m = 1'b0, ds = 1'b0;
    logic [23:0] acc = '0;
    ev_t p1 = '0, p2 = '0, ev = '0;
    logic e_pv = 1'b0, e_er = 1'b0, e_fe = 1'b0;
    logic [23:0] e_px = '0;
    logic [15:0] e_idx = '0, n_idx = '0;

    ws2812_rx dut (
        .clk_100mhz(clk),
        .reset_n   (reset_n),
        .d_in      (d_in),
        .red       (red),
        .green     (green),
        .blue      (blue),
        .pix_valid (pix_valid),
        .pix_idx   (pix_idx),
        .frame_end (frame_end),
        .err       (err)
    );

    initial forever #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Model: the line seen two samples late, judged by run lengths of each level.
    // Mode 0 waits for a long low, 1 is armed, 2 measures a high, 3 measures a low.
    initial forever begin
        @(posedge clk or negedge reset_n);
        if (!reset_n) begin
            mode = 0; run = 0; nbits = 0; lvl = 0; s1m = 0; acc = '0;
            p1 = '0; p2 = '0; e_pv = 0; e_er = 0; e_fe = 0; e_px = '0; e_idx = '0; n_idx = '0;
        end else begin
            e_pv = p2.pv; e_er = p2.er; e_fe = p2.fe;
            if (p2.pv) begin
                e_px = p2.px;
                e_idx = n_idx;
                if (n_idx != 16'hFFFF) n_idx = n_idx + 16'd1;
            end
            if (p2.fe) begin e_idx = '0; n_idx = '0; end
            p2 = p1;
            ev = '0;
            ds = s1m;
            s1m = d_in;
            width = run;
            run = (ds != lvl) ? 1 : run + 1;
            case (mode)
                0: if (!ds && run > RES_TIME) mode = 1;
                1: if (ds && !lvl) mode = 2;
                2: if (!ds) begin
                        if (width < MIN_HIGH) begin
                            ev.er = 1; mode = 0; nbits = 0;
                        end else begin
                            acc = {acc[22:0], width >= BIT_THRESH};
                            nbits++;
                            mode = 3;
                            if (nbits == 24) begin ev.pv = 1; ev.px = acc; nbits = 0; end
                        end
                    end else if (run > MAX_HIGH) begin
                        ev.er = 1; mode = 0; nbits = 0;
                    end
                default: if (ds) mode = 2;
                    else if (run > RES_TIME) begin
                        ev.fe = 1; ev.er = nbits != 0; nbits = 0; mode = 1;
                    end
            endcase
            lvl = ds;
            p1 = ev;
        end
    end

    initial forever begin
        @(negedge clk);
        checks++;
        if ({pix_valid, err, frame_end, green, red, blue, pix_idx} !== {e_pv, e_er, e_fe, e_px, e_idx}) begin
            fails++;
            if (fails < 20)
                $display("FAIL outputs cyc=%0d: got pv=%b err=%b fe=%b grb=%06h idx=%0d, required pv=%b err=%b fe=%b grb=%06h idx=%0d",
                         cyc, pix_valid, err, frame_end, {green, red, blue}, pix_idx, e_pv, e_er, e_fe, e_px, e_idx);
        end
        if (pix_valid) begin
            if (pv_n < 8) idx_log[pv_n] = int'(pix_idx);
            pv_n++; pv_cyc = cyc; last_grb = {green, red, blue}; last_idx = int'(pix_idx);
        end
        if (err) begin err_n++; err_cyc = cyc; end
        if (frame_end) begin fe_n++; fe_cyc = cyc; end
    end

    task automatic chk(input string nm, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0d (0x%0h), required %0d (0x%0h)", nm, got, got, exp, exp);
        end
    endtask

    task automatic drv(input logic v, input int n);
        @(posedge clk);
        #2 d_in = v;
        last_set = cyc;
        repeat (n - 1) @(posedge clk);
    endtask

    task automatic bits(input logic [23:0] w, input int nb);
        for (int i = 0; i < nb; i++) begin
            drv(1'b1, w[23-i] ? T1H : T0H);
            drv(1'b0, w[23-i] ? T1L : T0L);
            last_fall = last_set;
        end
    endtask

    task automatic clr();
        pv_n = 0; err_n = 0; fe_n = 0;
    endtask

    localparam int GAP = RES_TIME + 60;

    initial begin
        logic [23:0] px;
        int hi, np;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_outputs", int'({red, green, blue, pix_valid, err, frame_end}), 0);
        chk("reset_idx", int'(pix_idx), 0);
        @(posedge clk);
        #2 reset_n = 1'b1;

        // single nominal pixel
        drv(1'b0, GAP);
        clr();
        bits(24'h123456, 24);
        drv(1'b0, GAP);
        chk("single_pv_count", pv_n, 1);
        chk("single_red", int'(last_grb[15:8]), 8'h34);
        chk("single_green", int'(last_grb[23:16]), 8'h12);
        chk("single_blue", int'(last_grb[7:0]), 8'h56);
        chk("single_idx", last_idx, 0);
        chk("single_pv_latency", pv_cyc - last_fall, 4);
        chk("single_fe_count", fe_n, 1);
        chk("single_fe_latency", fe_cyc - last_fall, RES_TIME + 4);
        chk("single_err_count", err_n, 0);

        // threshold: 59 -> 0, 60 -> 1
        clr();
        for (int i = 23; i >= 0; i--) begin
            drv(1'b1, (i == 23) ? 59 : (i == 22) ? 60 : T0H);
            drv(1'b0, T0L);
        end
        drv(1'b0, GAP);
        chk("thresh_pv_count", pv_n, 1);
        chk("thresh_grb", int'(last_grb), 24'h400000);
        clr();
        drv(1'b1, 14);
        drv(1'b0, 100);
        last_fall = last_set;
        chk("short_err_count", err_n, 1);
        chk("short_err_latency", err_cyc - last_fall, 4);
        bits(24'hA5A5A5, 24);
        drv(1'b0, GAP);
        chk("short_no_pv", pv_n, 0);
        chk("short_no_fe", fe_n, 0);
        clr();
        bits(24'h0F0F0F, 24);
        drv(1'b0, GAP);
        chk("recover_pv_count", pv_n, 1);
        chk("recover_grb", int'(last_grb), 24'h0F0F0F);
        chk("recover_idx", last_idx, 0);

        // stuck high mid-word
        clr();
        bits(24'hFFFFFF, 5);
        drv(1'b1, 200);
        chk("stuck_err_latency", err_cyc - last_set, MAX_HIGH + 4);
        drv(1'b0, GAP);
        chk("stuck_err_count", err_n, 1);
        chk("stuck_no_fe", fe_n, 0);
        chk("stuck_no_pv", pv_n, 0);

        // partial frame of 23 bits
        clr();
        bits(24'h123456, 23);
        drv(1'b0, GAP);
        chk("partial_err_count", err_n, 1);
        chk("partial_fe_count", fe_n, 1);
        chk("partial_same_cycle", err_cyc, fe_cyc);
        chk("partial_no_pv", pv_n, 0);

        // three back-to-back pixels
        clr();
        bits(24'hFF0000, 24);
        bits(24'h00FF00, 24);
        bits(24'h0000FF, 24);
        drv(1'b0, GAP);
        chk("multi_pv_count", pv_n, 3);
        chk("multi_idx0", idx_log[0], 0);
        chk("multi_idx1", idx_log[1], 1);
        chk("multi_idx2", idx_log[2], 2);
        chk("multi_last_grb", int'(last_grb), 24'h0000FF);
        chk("multi_fe_count", fe_n, 1);
        @(negedge clk);
        chk("multi_idx_after_fe", int'(pix_idx), 0);

        // reset in the middle of a fourth pixel
        clr();
        bits(24'hABCDEF, 10);
        drv(1'b1, 20);
        @(posedge clk);
        #2 reset_n = 1'b0;
        d_in = 1'b0;
        @(negedge clk);
        chk("midreset_outputs", int'({red, green, blue, pix_valid, err, frame_end}), 0);
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        drv(1'b0, 100);
        bits(24'h112233, 24);
        drv(1'b0, GAP);
        chk("midreset_no_pv", pv_n, 0);
        chk("midreset_no_fe", fe_n, 0);
        chk("midreset_no_err", err_n, 0);
        clr();
        bits(24'h445566, 24);
        drv(1'b0, GAP);
        chk("midreset_pv_count", pv_n, 1);
        chk("midreset_grb", int'(last_grb), 24'h445566);
        chk("midreset_idx", last_idx, 0);

        // random traffic with jittered widths and occasional faults
        for (int f = 0; f < 4; f++) begin
            np = $urandom_range(1, 3);
            for (int p = 0; p < np; p++) begin
                px = 24'($urandom);
                for (int i = 23; i >= 0; i--) begin
                    hi = px[i] ? $urandom_range(60, 100) : $urandom_range(15, 59);
                    if ($urandom_range(0, 149) == 0) hi = $urandom_range(1, 14);
                    else if ($urandom_range(0, 299) == 0) hi = $urandom_range(121, 140);
                    drv(1'b1, hi);
                    drv(1'b0, $urandom_range(1, 40));
                end
            end
            if ($urandom_range(0, 3) == 0) begin
                np = $urandom_range(1, 23);
                for (int i = 0; i < np; i++) begin
                    drv(1'b1, $urandom_range(15, 100));
                    drv(1'b0, $urandom_range(1, 40));
                end
            end
            drv(1'b0, $urandom_range(RES_TIME + 50, RES_TIME + 300));
        end
        drv(1'b0, 10);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end
endmodule

// File: doc/ws2812_rx.md
# ws2812_rx

Single-wire WS2812 (NRZ, GRB, MSB-first) receiver for the ambilight LED path: it decodes a serial LED stream back into 24-bit pixels. It recovers each bit from its high-pulse width, assembles GRB words and emits one pixel per valid pulse. It also marks frame boundaries on reset gaps and flags malformed traffic. It serves as the loopback checker for the transmit path and as the input stage for daisy-chained captures.

## Interface
- MIN_HIGH, 15: shortest legal high pulse in clocks; anything shorter is an error.
- BIT_THRESH, 60: high width ≥ this decodes as 1, otherwise 0.
- MAX_HIGH, 120: longest legal high pulse in clocks.
- RES_TIME, 2000: continuous-low clocks that end a frame (20 µs at 100 MHz).
- clk_100mhz  in  1  system clock, 100 MHz.
- reset_n  in  1  asynchronous, active-low reset.
- d_in  in  1  serial line, asynchronous to clk_100mhz.
- red, green, blue  out  8 each  last decoded pixel; held between pix_valid pulses.
- pix_valid  out  1  one-cycle pulse when new red/green/blue are presented.
- pix_idx  out  16  index of the presented pixel within its frame; saturates at 0xFFFF.
- frame_end  out  1  one-cycle pulse when a reset gap is recognised.
- err  out  1  one-cycle pulse on a protocol violation.

## Operation
- d_in passes through a 2-FF synchroniser to give d_s; d_q is d_s delayed one cycle. A rise is d_s & !d_q; a fall is !d_s & d_q.
- A 16-bit saturating counter clears on every detected edge and otherwise increments. The high width w is the number of cycles d_s was 1.
- A 24-bit shift register takes bits MSB-first. A 5-bit bit counter runs 0..23.
- **SYNC** (the reset state): wait for RES_TIME consecutive low cycles, then enter IDLE. Rises before that restart the wait. Data is never accepted in SYNC.
- **IDLE**: a rise enters HIGH.
- **HIGH**:
  - On a fall: if w < MIN_HIGH, raise err and enter SYNC. Otherwise shift in (w ≥ BIT_THRESH) and enter LOW.
  - If w exceeds MAX_HIGH while the line is still high, raise err and enter SYNC.
- **LOW**:
  - A rise enters HIGH.
  - After RES_TIME low cycles: pulse frame_end, clear pix_idx and enter IDLE. If the bit counter is non-zero at that point, also pulse err and discard the partial word.
- **24th bit**: load green = sr[23:16], red = sr[15:8], blue = sr[7:0]. Pulse pix_valid. pix_idx carries this pixel's index, then advances for the next pixel. Clear the bit counter.
- **Any error**: discard the partial word. pix_idx keeps counting within the frame until frame_end.
- **Reset values**: red, green, blue = 0; pix_valid, frame_end, err = 0; pix_idx = 0; state = SYNC.
- **Reset mid-word**: the partial word is lost and no pulses are emitted. After release the block must again see RES_TIME of low before it accepts data.

## Timing
- A rising clock edge at which d_in is first sampled low is edge 0. pix_valid (for the 24th bit) and err (short-pulse case) are high in the cycle after edge 3. red/green/blue update on that same edge.
- Width is measured on d_s, so w has ±1 clock of jitter relative to d_in. At 100 MHz, T0H = 40 gives w of 39–41 and T1H = 80 gives w of 79–81.
- frame_end rises RES_TIME+3 cycles after d_in is first sampled low, counting from the last fall.
- err and frame_end may pulse in the same cycle. pix_valid and frame_end never do.
- Back-to-back pixels have no dead time: the first bit of the next word may start on the cycle after the 24th fall.

## Structure
- Shared package ws2812_pkg holds:
  - protocol timing constants T0H = 40, T0L = 85, T1H = 80, T1L = 45 (clocks at 100 MHz);
  - receiver defaults MIN_HIGH, BIT_THRESH, MAX_HIGH, RES_TIME;
  - the state encoding SYNC, IDLE, HIGH, LOW.
- Sub-module ws2812_sync contains the 2-FF synchroniser plus rise/fall detection, asynchronously reset to low.

## Test plan
- **Single pixel**: after 2000 clocks low, drive a nominal-timing word G=0x12, R=0x34, B=0x56 → one pix_valid with red=0x34, green=0x12, blue=0x56, pix_idx=0. Then hold low → frame_end about 2000 cycles later and err never asserted.
- **Bit threshold**: highs of w = 59 and w = 60 inside a word → decoded as 0 and 1 respectively. w = 14 → err, no pix_valid until the line has been low 2000 cycles again.
- **Stuck high**: line held high 200 clocks mid-word → err at w = 121, state SYNC, no frame_end until after the line returns low for 2000 cycles.
- **Partial frame**: 23 bits then a 2000-cycle gap → err and frame_end in the same cycle, no pix_valid.
- **Multi-pixel stream**: 3 pixels FF0000, 00FF00, 0000FF back-to-back with T0L/T1L gaps → pix_idx 0, 1, 2, then frame_end and pix_idx = 0. Then reset_n low mid-word of a 4th pixel → all outputs 0, no pulses, and after release the next pixel is accepted only after a 2000-cycle low.
